// File: rtl/if_fetch_slice.sv
// rtl/if_fetch_slice.sv - instruction-fetch stage with in-order prefetch queue
//
// Issues word fetches to instruction memory over req/gnt and collects in-order
// rvalid responses into a small prefetch queue. The queue head goes to decode as
// {PC_inc, instr}. A redirect (taken branch/call/ret) restarts fetching at
// redirect_pc and drops every response still owed for the old path.
//
// Optional feature macro: IF_RESP_BYPASS_EN. When defined, a response that
// arrives while the queue is empty goes straight to decode in the same cycle.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//   QDEPTH       prefetch capacity (2 or 4): outstanding + queued <= QDEPTH
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   stall        decode holding; queue head is not consumed
//   redirect     new fetch path resolved this cycle
//   redirect_pc  new fetch address, valid with redirect
//   imem_req     fetch request
//   imem_addr    fetch word address
//   imem_gnt     request accepted this cycle
//   imem_rvalid  response valid (in request order)
//   imem_rdata   fetched instruction
//   instr        instruction to decode (16'hF000 when bubble)
//   PC_inc       address of instr + 1 (16'h0000 when bubble)
//   instr_valid  instr is a real instruction
module if_fetch_slice #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] PC_inc,
    output logic        instr_valid
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [15:0]   fetch_pc;
    logic [15:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [15:0]   q_pc    [QDEPTH];
    logic [15:0]   q_instr [QDEPTH];

    logic          pop;
    logic          grant;
    logic          keep;
    logic          bypass;
    logic          push;
    logic [CW:0]   occupancy;

    assign pop = (count != '0) && !stall && !redirect;

    // Slots already promised: queued entries plus every granted request that
    // has not answered yet (discarded ones included, they still return data).
    assign occupancy = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};

    assign imem_req  = rst && !redirect && (occupancy < (CW + 1)'(QDEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    // A response is kept only if it belongs to the current path.
    assign keep = imem_rvalid && (discard == '0) && !redirect;

`ifdef IF_RESP_BYPASS_EN
    assign bypass = rst && keep && (count == '0) && !stall;
`else
    assign bypass = 1'b0;
`endif

    assign push = keep && !bypass;

    always_comb begin
        instr       = 16'hF000;
        PC_inc      = 16'h0000;
        instr_valid = 1'b0;
        if (count != '0) begin
            instr       = q_instr[head];
            PC_inc      = q_pc[head];
            instr_valid = 1'b1;
        end else if (bypass) begin
            instr       = imem_rdata;
            PC_inc      = resp_pc + 16'd1;
            instr_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                // Everything still unanswered after this cycle's response
                // belongs to the abandoned path.
                discard  <= inflight - CW'(imem_rvalid);
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 16'd1;
                end
                if (keep) begin
                    resp_pc <= resp_pc + 16'd1;
                end
                if (imem_rvalid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                if (push) begin
                    tail <= tail + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
            inflight <= inflight + CW'(grant) - CW'(imem_rvalid);
        end
    end

    // Queue storage carries no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]    <= resp_pc + 16'd1;
            q_instr[tail] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_slice.sv
// tb/tb_if_fetch_slice.sv - self-checking bench for if_fetch_slice
module tb_if_fetch_slice;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req    [2];
    logic [15:0] imem_addr   [2];
    logic        imem_gnt    [2];
    logic        imem_rvalid [2];
    logic [15:0] imem_rdata  [2];
    logic [15:0] instr       [2];
    logic [15:0] pc_inc      [2];
    logic        instr_valid [2];

    if_fetch_slice #(.RESET_PC(16'h0000), .QDEPTH(2)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req[0]), .imem_addr(imem_addr[0]),
        .imem_gnt(imem_gnt[0]), .imem_rvalid(imem_rvalid[0]), .imem_rdata(imem_rdata[0]),
        .instr(instr[0]), .PC_inc(pc_inc[0]), .instr_valid(instr_valid[0])
    );

    if_fetch_slice #(.RESET_PC(16'hFFFF), .QDEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req[1]), .imem_addr(imem_addr[1]),
        .imem_gnt(imem_gnt[1]), .imem_rvalid(imem_rvalid[1]), .imem_rdata(imem_rdata[1]),
        .instr(instr[1]), .PC_inc(pc_inc[1]), .instr_valid(instr_valid[1])
    );

    typedef struct packed { logic [15:0] addr; logic [31:0] ready; } mreq_t;
    typedef struct packed { logic [15:0] addr; logic stale; } oreq_t;
    typedef struct packed { logic [15:0] pc_inc; logic [15:0] ins; } ent_t;

    mreq_t       mem_q [2][$];
    oreq_t       out_q [2][$];
    ent_t        exp_q [2][$];
    logic [15:0] mpc        [2];
    int          last_ready [2];
    bit          fast_mem   [2];
    int          cyc;
    int          checks;
    int          failures;
    int          grants1;
    bit          seen1;

    logic        s_req;
    logic [15:0] s_addr;
    logic [15:0] s_instr;
    logic [15:0] s_pc;
    logic        s_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int qd(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    task automatic step();
        bit          rv    [2];
        bit          m_pop [2];
        bit          ereq  [2];
        bit          byp   [2];
        bit          gr    [2];
        bit          egr   [2];
        logic [15:0] saddr [2];
        for (int i = 0; i < 2; i++) begin
            rv[i] = (mem_q[i].size() > 0) && (int'(mem_q[i][0].ready) <= cyc);
            imem_rvalid[i] = rv[i];
            imem_rdata[i]  = rv[i] ? mem_q[i][0].addr + 16'h1000 : 16'h0000;
            imem_gnt[i]    = 1'b0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            imem_gnt[i] = imem_req[i] && (fast_mem[i] || ($urandom_range(0, 3) != 0));
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [15:0] e_ins;
            logic [15:0] e_pc;
            logic        e_val;
            if (rv[i]) chk($sformatf("d%0d_c%0d_resp_owed", i, cyc), out_q[i].size() > 0, 1'b1);
            m_pop[i] = (exp_q[i].size() > 0) && !stall && !redirect;
            ereq[i]  = !redirect &&
                       (out_q[i].size() + exp_q[i].size() - int'(m_pop[i]) < qd(i));
            byp[i] = 1'b0;
`ifdef IF_RESP_BYPASS_EN
            byp[i] = (exp_q[i].size() == 0) && rv[i] && (out_q[i].size() > 0) &&
                     !out_q[i][0].stale && !redirect && !stall;
`endif
            e_ins = 16'hF000;
            e_pc  = 16'h0000;
            e_val = 1'b0;
            if (exp_q[i].size() > 0) begin
                e_ins = exp_q[i][0].ins;
                e_pc  = exp_q[i][0].pc_inc;
                e_val = 1'b1;
            end else if (byp[i]) begin
                e_ins = out_q[i][0].addr + 16'h1000;
                e_pc  = out_q[i][0].addr + 16'd1;
                e_val = 1'b1;
            end
            chk($sformatf("d%0d_c%0d_req", i, cyc), imem_req[i], ereq[i]);
            if (ereq[i]) chk($sformatf("d%0d_c%0d_addr", i, cyc), imem_addr[i], mpc[i]);
            chk($sformatf("d%0d_c%0d_instr", i, cyc), instr[i], e_ins);
            chk($sformatf("d%0d_c%0d_pc_inc", i, cyc), pc_inc[i], e_pc);
            chk($sformatf("d%0d_c%0d_valid", i, cyc), instr_valid[i], e_val);
            if (i == 1 && !seen1 && instr_valid[1]) begin
                chk("d1_first_pc_inc", pc_inc[1], 16'h0000);
                seen1 = 1'b1;
            end
            gr[i]    = imem_req[i] && imem_gnt[i];
            egr[i]   = ereq[i] && imem_gnt[i];
            saddr[i] = imem_addr[i];
            if (i == 1 && gr[i]) begin
                grants1++;
                if (grants1 == 2) chk("d1_second_addr", imem_addr[1], 16'h0000);
            end
        end
        s_req   = imem_req[0];
        s_addr  = imem_addr[0];
        s_instr = instr[0];
        s_pc    = pc_inc[0];
        s_valid = instr_valid[0];

        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            oreq_t r;
            oreq_t o;
            mreq_t m;
            ent_t  e;
            bit    keep;
            int    rdy;
            keep = 1'b0;
            r    = '0;
            if (rv[i]) begin
                mem_q[i].pop_front();
                if (out_q[i].size() > 0) begin
                    r    = out_q[i].pop_front();
                    keep = !r.stale && !redirect && !byp[i];
                end
            end
            if (m_pop[i]) exp_q[i].pop_front();
            if (keep) begin
                e.pc_inc = r.addr + 16'd1;
                e.ins    = r.addr + 16'h1000;
                exp_q[i].push_back(e);
            end
            if (gr[i]) begin
                rdy = cyc + (fast_mem[i] ? 1 : int'($urandom_range(1, 3)));
                if (rdy <= last_ready[i]) rdy = last_ready[i] + 1;
                last_ready[i] = rdy;
                m.addr  = saddr[i];
                m.ready = rdy;
                mem_q[i].push_back(m);
            end
            if (egr[i]) begin
                o.addr  = mpc[i];
                o.stale = 1'b0;
                out_q[i].push_back(o);
                mpc[i] = mpc[i] + 16'd1;
            end
            if (redirect) begin
                exp_q[i].delete();
                for (int k = 0; k < out_q[i].size(); k++) begin
                    o = out_q[i][k];
                    o.stale = 1'b1;
                    out_q[i][k] = o;
                end
                mpc[i] = redirect_pc;
            end
            chk($sformatf("d%0d_c%0d_occupancy", i, cyc),
                (out_q[i].size() + exp_q[i].size()) <= qd(i), 1'b1);
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        grants1     = 0;
        seen1       = 1'b0;
        rst         = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        mpc[0]      = 16'h0000;
        mpc[1]      = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            imem_gnt[i]    = 1'b0;
            imem_rvalid[i] = 1'b0;
            imem_rdata[i]  = 16'h0000;
            last_ready[i]  = -1;
            fast_mem[i]    = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_rst_instr", i), instr[i], 16'hF000);
            chk($sformatf("d%0d_rst_pc_inc", i), pc_inc[i], 16'h0000);
            chk($sformatf("d%0d_rst_valid", i), instr_valid[i], 1'b0);
            chk($sformatf("d%0d_rst_req", i), imem_req[i], 1'b0);
        end
        rst = 1'b1;

        step();
        chk("dir_c0_req", s_req, 1'b1);
        chk("dir_c0_addr", s_addr, 16'h0000);
        step();
        chk("dir_c1_addr", s_addr, 16'h0001);
`ifdef IF_RESP_BYPASS_EN
        chk("dir_c1_instr", s_instr, 16'h1000);
        chk("dir_c1_pc_inc", s_pc, 16'h0001);
        chk("dir_c1_valid", s_valid, 1'b1);
`endif
        step();
        chk("dir_c2_addr", s_addr, 16'h0002);
`ifndef IF_RESP_BYPASS_EN
        chk("dir_c2_instr", s_instr, 16'h1000);
        chk("dir_c2_pc_inc", s_pc, 16'h0001);
        chk("dir_c2_valid", s_valid, 1'b1);
`endif
        step();
`ifndef IF_RESP_BYPASS_EN
        chk("dir_c3_instr", s_instr, 16'h1001);
`endif
        step();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
`ifndef IF_RESP_BYPASS_EN
            chk("dir_stall_instr", s_instr, 16'h1003);
            chk("dir_stall_pc_inc", s_pc, 16'h0004);
            chk("dir_stall_req", s_req, 1'b0);
`endif
        end
        stall = 1'b0;
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        step();
        chk("dir_redir_req", s_req, 1'b1);
        chk("dir_redir_addr", s_addr, 16'h0040);
        chk("dir_redir_bubble", s_valid, 1'b0);
        step();
`ifdef IF_RESP_BYPASS_EN
        chk("dir_redir_instr", s_instr, 16'h1040);
        chk("dir_redir_pc_inc", s_pc, 16'h0041);
`endif
        step();
`ifndef IF_RESP_BYPASS_EN
        chk("dir_redir_instr", s_instr, 16'h1040);
        chk("dir_redir_pc_inc", s_pc, 16'h0041);
`endif
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        chk("dir_coinc_valid", s_valid, 1'b0);
        chk("dir_coinc_instr", s_instr, 16'hF000);
        chk("dir_coinc_pc_inc", s_pc, 16'h0000);
        chk("dir_coinc_addr", s_addr, 16'h0100);

        fast_mem[0] = 1'b0;
        fast_mem[1] = 1'b0;
        for (int k = 0; k < 300; k++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = 16'($urandom);
            step();
        end
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
